// File: rtl/ins_fetch_if.sv
// Fetch-side bundle: start/redirect control, instruction-memory read port,
// decode handshake and status. The fetch unit is the master; the bench or
// the surrounding core is the slave.
interface ins_fetch_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_e;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_q;
  logic              ins_valid;
  logic              ins_ready;
  logic [DATA_W-1:0] ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              halted;
  logic              busy;

  modport master (
    input  start, start_pc, redirect_valid, redirect_pc, mem_q, ins_ready,
    output mem_e, mem_address, ins_valid, ins_data, ins_pc, halted, busy
  );

  modport slave (
    output start, start_pc, redirect_valid, redirect_pc, mem_q, ins_ready,
    input  mem_e, mem_address, ins_valid, ins_data, ins_pc, halted, busy
  );
endinterface

// File: rtl/ins_fetch.sv
// Instruction fetch sequencer: walks the PC through a one-cycle synchronous
// instruction memory and hands each word to decode with valid/ready.
// Sequence per word is REQ (read issued) -> RESP (data returns) -> HOLD
// (word presented), so a continuously ready decoder sees one word per 3 cycles.
module ins_fetch #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                MEM_DEPTH = 32,
  parameter logic [DATA_W-1:0] HALT_WORD = {DATA_W{1'b1}}
) (
  input  logic        clk,
  input  logic        rst,
  ins_fetch_if.master bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] REQ  = 3'd1;
  localparam logic [2:0] RESP = 3'd2;
  localparam logic [2:0] HOLD = 3'd3;
  localparam logic [2:0] HALT = 3'd4;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ins_data_q, ins_data_d;
  logic [ADDR_W-1:0] ins_pc_q, ins_pc_d;

  // An out-of-range target never issues a read; it parks the unit in HALT.
  function automatic logic [2:0] target_state(input logic [ADDR_W-1:0] tgt);
    return (tgt < DEPTH_A) ? REQ : HALT;
  endfunction

  // Next-state logic: redirect outranks capture and handshake in busy states.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ins_data_d = ins_data_q;
    ins_pc_d   = ins_pc_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          pc_d    = bus.start_pc;
          state_d = target_state(bus.start_pc);
        end
      end
      REQ: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = target_state(bus.redirect_pc);
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = target_state(bus.redirect_pc);
        end else begin
          ins_data_d = bus.mem_q;
          ins_pc_d   = pc_q;
          pc_d       = pc_q + 1'b1;
          state_d    = HOLD;
        end
      end
      HOLD: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = target_state(bus.redirect_pc);
        end else if (bus.ins_ready) begin
          state_d = ((ins_data_q == HALT_WORD) || (pc_q >= DEPTH_A)) ? HALT : REQ;
        end
      end
      HALT: begin
        if (bus.redirect_valid) begin
          pc_d    = bus.redirect_pc;
          state_d = target_state(bus.redirect_pc);
        end else if (bus.start) begin
          pc_d    = bus.start_pc;
          state_d = target_state(bus.start_pc);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, PC and captured instruction registers; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      ins_data_q <= '0;
      ins_pc_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ins_data_q <= ins_data_d;
      ins_pc_q   <= ins_pc_d;
    end
  end

  // Outputs are pure decodes of the state plus the held registers.
  always_comb begin
    bus.mem_e       = (state_q == REQ);
    bus.mem_address = pc_q;
    bus.ins_valid   = (state_q == HOLD);
    bus.ins_data    = ins_data_q;
    bus.ins_pc      = ins_pc_q;
    bus.halted      = (state_q == HALT);
    bus.busy        = (state_q == REQ) || (state_q == RESP) || (state_q == HOLD);
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a 32-word, one-cycle-read memory model.
module tb_ins_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] mem [32];
  int n_chk  = 0;
  int n_pass = 0;

  ins_fetch_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ins_fetch #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(32), .HALT_WORD(32'hFFFFFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_e) bus.mem_q <= mem[bus.mem_address[4:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_vld(input string tag);
    int i;
    for (i = 0; i < 20 && bus.ins_valid !== 1'b1; i++) step();
    chk(tag, {31'd0, bus.ins_valid}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic go(input logic [31:0] pc);
    bus.start_pc = pc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    mem[0] = 32'h0F0F0F0E;
    mem[1] = 32'h0C0C0C0C;
    for (int i = 2; i < 31; i++) mem[i] = 32'h80000000;
    mem[31] = 32'hFC0C0C0C;
    bus.mem_q = '0;
    bus.start = 1'b0;
    bus.start_pc = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.ins_ready = 1'b0;

    // Reset state
    do_reset();
    chk("rst_valid",  {31'd0, bus.ins_valid}, 32'd0);
    chk("rst_data",   bus.ins_data, 32'd0);
    chk("rst_pc",     bus.ins_pc, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy}, 32'd0);
    chk("rst_mem_e",  {31'd0, bus.mem_e}, 32'd0);
    chk("rst_addr",   bus.mem_address, 32'd0);

    // Basic fetch with backpressure on the first word
    go(32'd0);
    chk("t1_mem_e", {31'd0, bus.mem_e}, 32'd1);
    chk("t1_addr",  bus.mem_address, 32'd0);
    chk("t1_busy",  {31'd0, bus.busy}, 32'd1);
    step();
    chk("t1_resp_mem_e", {31'd0, bus.mem_e}, 32'd0);
    chk("t1_resp_valid", {31'd0, bus.ins_valid}, 32'd0);
    step();
    chk("t1_valid", {31'd0, bus.ins_valid}, 32'd1);
    chk("t1_data",  bus.ins_data, 32'h0F0F0F0E);
    chk("t1_pc",    bus.ins_pc, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", {31'd0, bus.ins_valid}, 32'd1);
      chk("t2_hold_data",  bus.ins_data, 32'h0F0F0F0E);
      chk("t2_hold_mem_e", {31'd0, bus.mem_e}, 32'd0);
    end
    bus.ins_ready = 1'b1;
    step();
    chk("t2_hs_valid", {31'd0, bus.ins_valid}, 32'd0);
    chk("t2_w1_mem_e", {31'd0, bus.mem_e}, 32'd1);
    chk("t2_w1_addr",  bus.mem_address, 32'd1);
    step();
    step();
    chk("t1_w1_valid", {31'd0, bus.ins_valid}, 32'd1);
    chk("t1_w1_data",  bus.ins_data, 32'h0C0C0C0C);
    chk("t1_w1_pc",    bus.ins_pc, 32'd1);

    // End of memory
    do_reset();
    bus.ins_ready = 1'b1;
    go(32'd30);
    wait_vld("t3_w30_wait");
    chk("t3_w30_data", bus.ins_data, 32'h80000000);
    chk("t3_w30_pc",   bus.ins_pc, 32'd30);
    step();
    wait_vld("t3_w31_wait");
    chk("t3_w31_data", bus.ins_data, 32'hFC0C0C0C);
    chk("t3_w31_pc",   bus.ins_pc, 32'd31);
    step();
    chk("t3_halted", {31'd0, bus.halted}, 32'd1);
    chk("t3_busy",   {31'd0, bus.busy}, 32'd0);
    chk("t3_valid",  {31'd0, bus.ins_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_idle_mem_e", {31'd0, bus.mem_e}, 32'd0);
      chk("t3_still_halted", {31'd0, bus.halted}, 32'd1);
    end
    go(32'd0);
    chk("t3_restart_halted", {31'd0, bus.halted}, 32'd0);
    chk("t3_restart_mem_e",  {31'd0, bus.mem_e}, 32'd1);
    wait_vld("t3_restart_wait");
    chk("t3_restart_data", bus.ins_data, 32'h0F0F0F0E);
    chk("t3_restart_pc",   bus.ins_pc, 32'd0);

    // Redirect during RESP
    do_reset();
    bus.ins_ready = 1'b1;
    go(32'd2);
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd1;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4a_valid", {31'd0, bus.ins_valid}, 32'd0);
    chk("t4a_mem_e", {31'd0, bus.mem_e}, 32'd1);
    chk("t4a_addr",  bus.mem_address, 32'd1);
    wait_vld("t4a_wait");
    chk("t4a_pc",   bus.ins_pc, 32'd1);
    chk("t4a_data", bus.ins_data, 32'h0C0C0C0C);

    // Redirect during HOLD, with ready also high
    do_reset();
    bus.ins_ready = 1'b0;
    go(32'd2);
    wait_vld("t4b_w2_wait");
    chk("t4b_w2_pc", bus.ins_pc, 32'd2);
    bus.ins_ready = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd1;
    step();
    bus.redirect_valid = 1'b0;
    chk("t4b_valid", {31'd0, bus.ins_valid}, 32'd0);
    chk("t4b_addr",  bus.mem_address, 32'd1);
    wait_vld("t4b_wait");
    chk("t4b_pc",   bus.ins_pc, 32'd1);
    chk("t4b_data", bus.ins_data, 32'h0C0C0C0C);

    // Halt word
    mem[5] = 32'hFFFFFFFF;
    do_reset();
    bus.ins_ready = 1'b1;
    go(32'd4);
    wait_vld("t5_w4_wait");
    chk("t5_w4_pc",   bus.ins_pc, 32'd4);
    chk("t5_w4_data", bus.ins_data, 32'h80000000);
    step();
    wait_vld("t5_w5_wait");
    chk("t5_w5_pc",   bus.ins_pc, 32'd5);
    chk("t5_w5_data", bus.ins_data, 32'hFFFFFFFF);
    step();
    chk("t5_halted", {31'd0, bus.halted}, 32'd1);
    chk("t5_mem_e",  {31'd0, bus.mem_e}, 32'd0);

    // Out-of-range start
    do_reset();
    go(32'd40);
    chk("t5_oor_halted", {31'd0, bus.halted}, 32'd1);
    chk("t5_oor_mem_e",  {31'd0, bus.mem_e}, 32'd0);
    chk("t5_oor_busy",   {31'd0, bus.busy}, 32'd0);
    step();
    chk("t5_oor_mem_e2", {31'd0, bus.mem_e}, 32'd0);

    // Reset while holding a word
    do_reset();
    bus.ins_ready = 1'b0;
    go(32'd0);
    wait_vld("t6_wait");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_valid",  {31'd0, bus.ins_valid}, 32'd0);
    chk("t6_data",   bus.ins_data, 32'd0);
    chk("t6_halted", {31'd0, bus.halted}, 32'd0);
    chk("t6_busy",   {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t6_no_deliver", {31'd0, bus.ins_valid}, 32'd0);
      chk("t6_no_read",    {31'd0, bus.mem_e}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
